// File: rtl/seq_serializer.sv
// Parallel-to-serial front end for the serial sequence detector: a one-word hold
// buffer feeds a shifter that emits len bits per word, with an optional idle gap.
module seq_serializer #(
    parameter int   WORD_W     = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_BIT   = 1'b0,
    parameter int   GAP_CYCLES = 0,
    localparam int  LEN_W      = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] word_in,
    input  logic [LEN_W-1:0]  len_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              data_out,
    output logic              bit_valid,
    output logic              busy,
    output logic [15:0]       words_sent
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    localparam logic [LEN_W-1:0] WORD_LEN = LEN_W'(WORD_W);
    localparam logic [3:0]       GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t            state_q, state_d;
    logic              hold_full_q, hold_full_d;
    logic [WORD_W-1:0] hold_word_q, hold_word_d;
    logic [LEN_W-1:0]  hold_len_q, hold_len_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        gap_q, gap_d;
    logic              ready_q, ready_d;
    logic              data_q, data_d;
    logic              valid_q, valid_d;
    logic [15:0]       sent_q, sent_d;

    logic              accept;
    logic              load;
    logic              last_bit;
    logic [LEN_W-1:0]  len_eff;
    logic [WORD_W-1:0] aligned;

    assign accept   = word_valid && ready_q;
    assign last_bit = (cnt_q == LEN_W'(1));
    assign len_eff  = (len_in == '0 || len_in > WORD_LEN) ? WORD_LEN : len_in;
    // MSB-first words are left-aligned so the first bit always sits at the top.
    assign aligned  = MSB_FIRST ? (hold_word_q << (WORD_LEN - hold_len_q)) : hold_word_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        state_d     = state_q;
        hold_full_d = hold_full_q;
        hold_word_d = hold_word_q;
        hold_len_d  = hold_len_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        data_d      = IDLE_BIT;
        valid_d     = 1'b0;
        sent_d      = sent_q;
        load        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (hold_full_q) load = 1'b1;
            end
            S_SHIFT: begin
                if (!last_bit) begin
                    valid_d = 1'b1;
                    cnt_d   = cnt_q - LEN_W'(1);
                    data_d  = MSB_FIRST ? shift_q[WORD_W-1] : shift_q[0];
                    shift_d = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
                end else begin
                    if (sent_q != 16'hFFFF) sent_d = sent_q + 16'd1;
                    if (GAP_CYCLES > 0) begin
                        state_d = S_GAP;
                        gap_d   = GAP_LOAD;
                    end else if (hold_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gap_q != 4'd0)    gap_d   = gap_q - 4'd1;
                else if (hold_full_q) load    = 1'b1;
                else                  state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Loading drives the first bit immediately so there is no bubble between words.
        if (load) begin
            state_d     = S_SHIFT;
            cnt_d       = hold_len_q;
            hold_full_d = 1'b0;
            valid_d     = 1'b1;
            data_d      = MSB_FIRST ? aligned[WORD_W-1] : aligned[0];
            shift_d     = MSB_FIRST ? (aligned << 1) : (aligned >> 1);
        end

        if (accept) begin
            hold_full_d = 1'b1;
            hold_word_d = word_in;
            hold_len_d  = len_eff;
        end

        ready_d = !hold_full_d;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state_q     <= S_IDLE;
            hold_full_q <= 1'b0;
            hold_word_q <= '0;
            hold_len_q  <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            ready_q     <= 1'b0;
            data_q      <= IDLE_BIT;
            valid_q     <= 1'b0;
            sent_q      <= '0;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            hold_word_q <= hold_word_d;
            hold_len_q  <= hold_len_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            ready_q     <= ready_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            sent_q      <= sent_d;
        end
    end

    assign word_ready = ready_q;
    assign data_out   = data_q;
    assign bit_valid  = valid_q;
    assign busy       = hold_full_q || (state_q != S_IDLE);
    assign words_sent = sent_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Self-checking bench for seq_serializer: three builds (default, GAP_CYCLES=2,
// LSB-first) driven with table vectors plus hand-written multi-cycle sequences.
module tb_seq_serializer;

    localparam int WORD_W = 8;
    localparam int LEN_W  = $clog2(WORD_W + 1);
    localparam int NS     = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset = 1'b1;
    logic [WORD_W-1:0] word_in = '0;
    logic [LEN_W-1:0]  len_in = '0;
    logic              val_a = 1'b0, val_b = 1'b0, val_c = 1'b0;
    logic              rdy_a, rdy_b, rdy_c;
    logic              dout_a, dout_b, dout_c;
    logic              bv_a, bv_b, bv_c;
    logic              busy_a, busy_b, busy_c;
    logic [15:0]       ws_a, ws_b, ws_c;

    seq_serializer #(.WORD_W(WORD_W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .GAP_CYCLES(0)) u_a (
        .clk(clk), .reset(reset), .word_in(word_in), .len_in(len_in), .word_valid(val_a),
        .word_ready(rdy_a), .data_out(dout_a), .bit_valid(bv_a), .busy(busy_a), .words_sent(ws_a));
    seq_serializer #(.WORD_W(WORD_W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .GAP_CYCLES(2)) u_b (
        .clk(clk), .reset(reset), .word_in(word_in), .len_in(len_in), .word_valid(val_b),
        .word_ready(rdy_b), .data_out(dout_b), .bit_valid(bv_b), .busy(busy_b), .words_sent(ws_b));
    seq_serializer #(.WORD_W(WORD_W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0), .GAP_CYCLES(0)) u_c (
        .clk(clk), .reset(reset), .word_in(word_in), .len_in(len_in), .word_valid(val_c),
        .word_ready(rdy_c), .data_out(dout_c), .bit_valid(bv_c), .busy(busy_c), .words_sent(ws_c));

    // Every negedge sample is logged so bit timing can be analysed after the fact.
    int   neg_cnt = 0;
    logic smp_bv   [3][NS];
    logic smp_dout [3][NS];

    always @(negedge clk) begin
        if (neg_cnt < NS) begin
            smp_bv[0][neg_cnt]   <= bv_a;
            smp_bv[1][neg_cnt]   <= bv_b;
            smp_bv[2][neg_cnt]   <= bv_c;
            smp_dout[0][neg_cnt] <= dout_a;
            smp_dout[1][neg_cnt] <= dout_b;
            smp_dout[2][neg_cnt] <= dout_c;
        end
        neg_cnt <= neg_cnt + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ws [3] = '{0, 0, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic get_ready(input int inst);
        case (inst)
            0:       return rdy_a;
            1:       return rdy_b;
            default: return rdy_c;
        endcase
    endfunction

    function automatic logic [15:0] get_ws(input int inst);
        case (inst)
            0:       return ws_a;
            1:       return ws_b;
            default: return ws_c;
        endcase
    endfunction

    task automatic set_valid(input int inst, input logic v);
        case (inst)
            0:       val_a = v;
            1:       val_b = v;
            default: val_c = v;
        endcase
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int inst, input logic [7:0] w, input logic [LEN_W-1:0] l,
                        input bit drop, output int acc_neg);
        word_in = w;
        len_in  = l;
        set_valid(inst, 1'b1);
        acc_neg = -1;
        for (int t = 0; t < 100; t++) begin
            if (get_ready(inst)) begin
                acc_neg = neg_cnt;
                break;
            end
            @(negedge clk);
        end
        if (acc_neg < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: inst %0d never raised word_ready", inst);
        end
        @(negedge clk);
        if (drop) set_valid(inst, 1'b0);
    endtask

    task automatic wait_sent(input int inst, input int target, input int budget);
        int t = 0;
        while (get_ws(inst) != 16'(target) && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (get_ws(inst) != 16'(target)) begin
            n_checks++;
            n_fail++;
            $display("FAIL sent_timeout: inst %0d words_sent=%0d, required %0d", inst, get_ws(inst), target);
        end
    endtask

    task automatic collect(input int inst, input int from, input int to, output int n,
                           output logic [31:0] val, output int first, output bit contig);
        int last = -1;
        n = 0;
        val = '0;
        first = -1;
        contig = 1'b1;
        for (int i = from; i < to && i < NS; i++) begin
            if (smp_bv[inst][i]) begin
                if (n == 0) first = i;
                else if (i != last + 1) contig = 1'b0;
                last = i;
                val = {val[30:0], smp_dout[inst][i]};
                n++;
            end
        end
    endtask

    typedef struct {
        int               inst;
        logic [7:0]       word;
        logic [LEN_W-1:0] len;
        int               n;
        logic [31:0]      bits;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int          acc, acc2, start, n, first, seen;
        logic [31:0] val;
        bit          contig;
        logic [5:0]  bv_pat, do_pat;

        vecs[0] = '{0, 8'h0B, 4'd4, 4, 32'h0B};
        vecs[1] = '{0, 8'hA5, 4'd0, 8, 32'hA5};
        vecs[2] = '{0, 8'h3C, 4'd8, 8, 32'h3C};
        vecs[3] = '{0, 8'h05, 4'd9, 8, 32'h05};
        vecs[4] = '{0, 8'h03, 4'd1, 1, 32'h01};
        vecs[5] = '{0, 8'h80, 4'd2, 2, 32'h00};
        vecs[6] = '{2, 8'h01, 4'd8, 8, 32'h80};
        vecs[7] = '{2, 8'h0D, 4'd9, 8, 32'hB0};

        // Reset held for 5 cycles, then released.
        repeat (5) @(negedge clk);
        check("rst_data_out", 32'(dout_a), 32'd0);
        check("rst_bit_valid", 32'(bv_a), 32'd0);
        check("rst_word_ready", 32'(rdy_a), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(rdy_a), 32'd1);
        check("post_rst_words_sent", 32'(ws_a), 32'd0);
        check("post_rst_busy", 32'(busy_a), 32'd0);

        // Single-word vectors.
        for (int i = 0; i < 8; i++) begin
            start = neg_cnt;
            send(vecs[i].inst, vecs[i].word, vecs[i].len, 1'b1, acc);
            exp_ws[vecs[i].inst]++;
            wait_sent(vecs[i].inst, exp_ws[vecs[i].inst], 40);
            repeat (2) @(negedge clk);
            collect(vecs[i].inst, start, neg_cnt, n, val, first, contig);
            check($sformatf("v%0d_nbits", i), 32'(n), 32'(vecs[i].n));
            check($sformatf("v%0d_bits", i), val, vecs[i].bits);
            check($sformatf("v%0d_contig", i), 32'(contig), 32'd1);
            check($sformatf("v%0d_latency", i), 32'(first - acc), 32'd2);
            check($sformatf("v%0d_words_sent", i), 32'(get_ws(vecs[i].inst)), 32'(exp_ws[vecs[i].inst]));
        end

        // Back-to-back A5 then 3C with valid held: 16 contiguous bits.
        start = neg_cnt;
        send(0, 8'hA5, 4'd0, 1'b0, acc);
        send(0, 8'h3C, 4'd0, 1'b1, acc2);
        check("b2b_ready_low_after_accept", 32'(rdy_a), 32'd0);
        exp_ws[0] += 2;
        wait_sent(0, exp_ws[0], 60);
        repeat (2) @(negedge clk);
        collect(0, start, neg_cnt, n, val, first, contig);
        check("b2b_nbits", 32'(n), 32'd16);
        check("b2b_bits", val, 32'h0000A53C);
        check("b2b_contig", 32'(contig), 32'd1);
        check("b2b_latency", 32'(first - acc), 32'd2);
        check("b2b_words_sent", 32'(ws_a), 32'(exp_ws[0]));

        // GAP_CYCLES=2: FF len 2 twice -> 1,1, two idle cycles, 1,1.
        start = neg_cnt;
        send(1, 8'hFF, 4'd2, 1'b0, acc);
        send(1, 8'hFF, 4'd2, 1'b1, acc2);
        exp_ws[1] += 2;
        wait_sent(1, exp_ws[1], 60);
        repeat (2) @(negedge clk);
        collect(1, start, neg_cnt, n, val, first, contig);
        check("gap_nbits", 32'(n), 32'd4);
        bv_pat = '0;
        do_pat = '0;
        if (first >= 0 && first + 5 < NS) begin
            for (int i = 0; i < 6; i++) begin
                bv_pat = {bv_pat[4:0], smp_bv[1][first + i]};
                do_pat = {do_pat[4:0], smp_dout[1][first + i]};
            end
        end
        check("gap_bit_valid_pattern", 32'(bv_pat), 32'b110011);
        check("gap_data_out_pattern", 32'(do_pat), 32'b110011);
        check("gap_words_sent", 32'(ws_b), 32'(exp_ws[1]));

        // Reset after 3 bits of FF with a second word waiting in the hold buffer.
        send(0, 8'hFF, 4'd8, 1'b0, acc);
        word_in = 8'h0F;
        len_in  = 4'd8;
        seen = 0;
        for (int t = 0; t < 20 && seen < 3; t++) begin
            if (bv_a) seen++;
            if (seen < 3) @(negedge clk);
        end
        check("mid_bits_before_reset", 32'(seen), 32'd3);
        check("mid_busy_before_reset", 32'(busy_a), 32'd1);
        reset = 1'b1;
        val_a = 1'b0;
        @(negedge clk);
        check("mid_rst_bit_valid", 32'(bv_a), 32'd0);
        check("mid_rst_data_out", 32'(dout_a), 32'd0);
        check("mid_rst_words_sent", 32'(ws_a), 32'd0);
        check("mid_rst_ready", 32'(rdy_a), 32'd0);
        reset = 1'b0;
        exp_ws = '{0, 0, 0};
        @(negedge clk);
        check("mid_release_ready", 32'(rdy_a), 32'd1);
        check("mid_release_busy", 32'(busy_a), 32'd0);
        start = neg_cnt;
        send(0, 8'h96, 4'd8, 1'b1, acc);
        exp_ws[0]++;
        wait_sent(0, exp_ws[0], 40);
        repeat (2) @(negedge clk);
        collect(0, start, neg_cnt, n, val, first, contig);
        check("after_rst_nbits", 32'(n), 32'd8);
        check("after_rst_bits", val, 32'h96);
        check("after_rst_latency", 32'(first - acc), 32'd2);
        check("after_rst_words_sent", 32'(ws_a), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
